i2c_target: RTL and testbench



---
 rtl/i2c_target_if.sv | 35 +++
 rtl/i2c_target.sv | 240 ++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// Local-side handshake between the I2C target and the register/peripheral it fronts.
// tx_valid is only present when I2C_TARGET_STRETCH_EN is defined.
interface i2c_target_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
`ifdef I2C_TARGET_STRETCH_EN
    logic                  tx_valid;
`endif
    logic                  tx_req;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rd_mode;
    logic                  busy;

`ifdef I2C_TARGET_STRETCH_EN
    modport master (
        output tx_data, output tx_valid,
        input  tx_req, input rx_data, input rx_valid, input rd_mode, input busy
    );
    modport slave (
        input  tx_data, input tx_valid,
        output tx_req, output rx_data, output rx_valid, output rd_mode, output busy
    );
`else
    modport master (
        output tx_data,
        input  tx_req, input rx_data, input rx_valid, input rd_mode, input busy
    );
    modport slave (
        input  tx_data,
        output tx_req, output rx_data, output rx_valid, output rd_mode, output busy
    );
`endif
endinterface

// File: rtl/i2c_target.sv
// Fixed-address I2C target bridging bus byte transfers to a local handshake.
// Define I2C_TARGET_STRETCH_EN to add tx_valid and SCL clock stretching on reads.
module i2c_target #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire         sda,
    inout  wire         scl,
    i2c_target_if.slave host
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

    logic sda_p0, sda_p1, sda_p2, sda_p3;
    logic scl_p0, scl_p1, scl_p2;
    logic start_p3, stop_p3, scl_rise_p3, scl_fall_p3;

    state_t                state, state_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic [DATA_WIDTH-1:0] rx_data, rx_data_n;
    logic                  sda_low, sda_low_n;
    logic                  busy, busy_n;
    logic                  rd_mode, rd_mode_n;
    logic                  rx_valid, rx_valid_n;
    logic                  tx_req, tx_req_n;
    logic                  load_pend, load_pend_n;
`ifdef I2C_TARGET_STRETCH_EN
    logic                  scl_low, scl_low_n;
`endif

    // Synchronizers idle high so reset never fabricates a bus event.
    always_ff @(posedge clock) begin
        if (reset) begin
            sda_p0      <= 1'b1;
            sda_p1      <= 1'b1;
            sda_p2      <= 1'b1;
            sda_p3      <= 1'b1;
            scl_p0      <= 1'b1;
            scl_p1      <= 1'b1;
            scl_p2      <= 1'b1;
            start_p3    <= 1'b0;
            stop_p3     <= 1'b0;
            scl_rise_p3 <= 1'b0;
            scl_fall_p3 <= 1'b0;
        end else begin
            sda_p0      <= sda;
            sda_p1      <= sda_p0;
            sda_p2      <= sda_p1;
            scl_p0      <= scl;
            scl_p1      <= scl_p0;
            scl_p2      <= scl_p1;
            sda_p3      <= sda_p1;
            start_p3    <= scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
            stop_p3     <= scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
            scl_rise_p3 <= scl_p1 & ~scl_p2;
            scl_fall_p3 <= ~scl_p1 & scl_p2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            rx_data   <= '0;
            sda_low   <= 1'b0;
            busy      <= 1'b0;
            rd_mode   <= 1'b0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            load_pend <= 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_low   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            rx_data   <= rx_data_n;
            sda_low   <= sda_low_n;
            busy      <= busy_n;
            rd_mode   <= rd_mode_n;
            rx_valid  <= rx_valid_n;
            tx_req    <= tx_req_n;
            load_pend <= load_pend_n;
`ifdef I2C_TARGET_STRETCH_EN
            scl_low   <= scl_low_n;
`endif
        end
    end

    always_ff @(posedge clock) begin
        shift <= shift_n;
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        rx_data_n   = rx_data;
        sda_low_n   = sda_low;
        busy_n      = busy;
        rd_mode_n   = rd_mode;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        load_pend_n = load_pend;
`ifdef I2C_TARGET_STRETCH_EN
        scl_low_n   = scl_low;
`endif

        if (start_p3 || stop_p3) begin
            state_n     = start_p3 ? ADDR : IDLE;
            bit_cnt_n   = 4'd0;
            sda_low_n   = 1'b0;
            busy_n      = 1'b0;
            load_pend_n = 1'b0;
`ifdef I2C_TARGET_STRETCH_EN
            scl_low_n   = 1'b0;
`endif
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise_p3) begin
                        shift_n   = {shift[DATA_WIDTH-2:0], sda_p3};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall_p3 && bit_cnt == LAST_BIT) begin
                        if (shift[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) begin
                            sda_low_n = 1'b1;
                            busy_n    = 1'b1;
                            rd_mode_n = shift[0];
                            state_n   = ADDR_ACK;
                        end else begin
                            state_n   = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_p3) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                        if (rd_mode) begin
                            tx_req_n    = 1'b1;
                            load_pend_n = 1'b1;
                            state_n     = READ;
                        end else begin
                            state_n     = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise_p3) begin
                        shift_n   = {shift[DATA_WIDTH-2:0], sda_p3};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall_p3 && bit_cnt == LAST_BIT) begin
                        rx_data_n  = shift;
                        rx_valid_n = 1'b1;
                        sda_low_n  = 1'b1;
                        state_n    = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall_p3) begin
                        sda_low_n = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = WRITE;
                    end
                end
                READ: begin
                    // tx_data is taken at the end of the cycle in which tx_req is high.
                    if (load_pend) begin
`ifdef I2C_TARGET_STRETCH_EN
                        if (host.tx_valid) begin
                            shift_n     = host.tx_data;
                            sda_low_n   = ~host.tx_data[DATA_WIDTH-1];
                            bit_cnt_n   = 4'd1;
                            load_pend_n = 1'b0;
                            scl_low_n   = 1'b0;
                        end else begin
                            tx_req_n    = 1'b1;
                            scl_low_n   = 1'b1;
                        end
`else
                        shift_n     = host.tx_data;
                        sda_low_n   = ~host.tx_data[DATA_WIDTH-1];
                        bit_cnt_n   = 4'd1;
                        load_pend_n = 1'b0;
`endif
                    end else if (scl_fall_p3) begin
                        if (bit_cnt == LAST_BIT) begin
                            sda_low_n = 1'b0;
                            state_n   = READ_ACK;
                        end else begin
                            sda_low_n = ~shift[DATA_WIDTH-2];
                            shift_n   = {shift[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                READ_ACK: begin
                    // A NACK ends the read at once; an ACK fetches the next byte on the fall.
                    if (scl_rise_p3 && sda_p3) begin
                        busy_n  = 1'b0;
                        state_n = WAIT_STOP;
                    end else if (scl_fall_p3) begin
                        tx_req_n    = 1'b1;
                        load_pend_n = 1'b1;
                        bit_cnt_n   = 4'd0;
                        state_n     = READ;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_n = state;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;
`ifdef I2C_TARGET_STRETCH_EN
    assign scl = scl_low ? 1'b0 : 1'bz;
`else
    assign scl = 1'bz;
`endif

    assign host.tx_req   = tx_req;
    assign host.rx_data  = rx_data;
    assign host.rx_valid = rx_valid;
    assign host.rd_mode  = rd_mode;
    assign host.busy     = busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench acting as I2C controller; expectations are queued by the stimulus and
// consumed by a scoreboard process watching rx_valid, tx_req and bus samples.
module tb_i2c_target;
    localparam int T = 10;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic sda_drv_low = 1'b0;
    logic scl_drv_low = 1'b0;
    wire  sda;
    wire  scl;
    assign sda = sda_drv_low ? 1'b0 : 1'bz;
    assign scl = scl_drv_low ? 1'b0 : 1'bz;
    pullup pu_sda (sda);
    pullup pu_scl (scl);

    i2c_target_if #(.DATA_WIDTH(8)) host ();

    i2c_target dut (
        .clock (clock),
        .reset (reset),
        .sda   (sda),
        .scl   (scl),
        .host  (host)
    );

    int checks = 0;
    int errors = 0;
    int exp_rx[$];
    int exp_ack[$];
    int obs_ack[$];
    int exp_byte[$];
    int obs_byte[$];
    int tx_supply[$];   // bit 8 set = hold tx_valid low to force a stretch
    int dut_sda_low_clks = 0;
    int dut_scl_low_clks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (scl !== 1'b1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (scl !== 1'b1) check("scl_release_timeout", int'(scl === 1'b1), 1);
    endtask

    task automatic bus_start();
        sda_drv_low = 1'b0;
        clk(T);
        scl_drv_low = 1'b0;
        wait_scl_high();
        clk(T);
        sda_drv_low = 1'b1;
        clk(T);
        scl_drv_low = 1'b1;
        clk(T);
    endtask

    task automatic bus_stop(input bit chk_busy);
        int n;
        sda_drv_low = 1'b1;
        clk(T);
        scl_drv_low = 1'b0;
        wait_scl_high();
        clk(T);
        sda_drv_low = 1'b0;
        if (chk_busy) begin
            n = 0;
            while (host.busy && n < 20) begin
                @(negedge clock);
                n++;
            end
            check("busy_drop_3_to_4_clks", (n >= 3 && n <= 4) ? 1 : 0, 1);
        end
        clk(2 * T);
    endtask

    task automatic write_bit(input bit b);
        sda_drv_low = ~b;
        clk(T);
        scl_drv_low = 1'b0;
        wait_scl_high();
        clk(2 * T);
        scl_drv_low = 1'b1;
        clk(T);
    endtask

    task automatic read_bit(output int b);
        sda_drv_low = 1'b0;
        clk(T);
        scl_drv_low = 1'b0;
        wait_scl_high();
        clk(T);
        b = (sda === 1'b1) ? 1 : 0;
        clk(T);
        scl_drv_low = 1'b1;
        clk(T);
    endtask

    task automatic wr_byte(input logic [7:0] v);
        int a;
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(a);
        obs_ack.push_back(a);
    endtask

    task automatic rd_byte(input bit nack);
        logic [7:0] v;
        int b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b[0];
        end
        obs_byte.push_back(int'(v));
        write_bit(nack);
    endtask

    // Clocks in which a line is low while the bench is not pulling it.
    initial begin : line_monitor
        forever begin
            @(negedge clock);
            if (sda === 1'b0 && !sda_drv_low) dut_sda_low_clks++;
            if (scl === 1'b0 && !scl_drv_low) dut_scl_low_clks++;
        end
    end

    initial begin : responder
        bit  prev;
        int  v;
        int  n;
        bit  mid_low;
        bit  held_req;
        prev = 1'b0;
        host.tx_data = 8'h00;
`ifdef I2C_TARGET_STRETCH_EN
        host.tx_valid = 1'b1;
`endif
        forever begin
            @(negedge clock);
            if (host.tx_req && !prev) begin
                if (tx_supply.size() == 0) begin
                    check("tx_req_unexpected", tx_supply.size(), 1);
                end else begin
                    v = tx_supply.pop_front();
                    host.tx_data = v[7:0];
`ifdef I2C_TARGET_STRETCH_EN
                    if (v[8]) begin
                        host.tx_valid = 1'b0;
                        n = 0;
                        mid_low = 1'b0;
                        held_req = 1'b0;
                        while (scl !== 1'b1 && n < 500) begin
                            @(negedge clock);
                            n++;
                            if (n == 40) begin
                                mid_low  = (scl === 1'b0);
                                held_req = host.tx_req;
                            end
                            if (n == 50) host.tx_valid = 1'b1;
                        end
                        check("stretch_scl_low_mid", int'(mid_low), 1);
                        check("stretch_tx_req_held", int'(held_req), 1);
                        check("stretch_release_50_to_53", (n >= 50 && n <= 53) ? 1 : 0, 1);
                    end
`endif
                end
            end
            prev = host.tx_req;
        end
    end

    initial begin : scoreboard
        int o;
        forever begin
            @(negedge clock);
            if (host.rx_valid) begin
                if (exp_rx.size() == 0) check("rx_valid_unexpected", exp_rx.size(), 1);
                else check("rx_data", int'(host.rx_data), exp_rx.pop_front());
            end
            while (obs_ack.size() > 0) begin
                o = obs_ack.pop_front();
                if (exp_ack.size() == 0) check("ack_unexpected", exp_ack.size(), 1);
                else check("ack_bit", o, exp_ack.pop_front());
            end
            while (obs_byte.size() > 0) begin
                o = obs_byte.pop_front();
                if (exp_byte.size() == 0) check("rd_byte_unexpected", exp_byte.size(), 1);
                else check("rd_byte", o, exp_byte.pop_front());
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b;
        int sda_base;
        reset = 1'b1;
        clk(3);
        check("rst_sda", int'(sda === 1'b1), 1);
        check("rst_scl", int'(scl === 1'b1), 1);
        check("rst_rx_data", int'(host.rx_data), 0);
        check("rst_tx_req", int'(host.tx_req), 0);
        check("rst_rx_valid", int'(host.rx_valid), 0);
        check("rst_rd_mode", int'(host.rd_mode), 0);
        check("rst_busy", int'(host.busy), 0);
        reset = 1'b0;
        clk(5);

        // single-byte write
        exp_ack.push_back(0); exp_ack.push_back(0);
        exp_rx.push_back(8'hA5);
        bus_start();
        wr_byte(8'h84);
        check("wr_rd_mode", int'(host.rd_mode), 0);
        check("wr_busy_after_addr", int'(host.busy), 1);
        wr_byte(8'hA5);
        check("wr_busy_before_stop", int'(host.busy), 1);
        bus_stop(1'b1);

        // address mismatch
        sda_base = dut_sda_low_clks;
        exp_ack.push_back(1); exp_ack.push_back(1);
        bus_start();
        wr_byte(8'h86);
        check("mis_busy", int'(host.busy), 0);
        wr_byte(8'h11);
        bus_stop(1'b0);
        check("mis_sda_never_driven", dut_sda_low_clks - sda_base, 0);
        check("mis_rx_data_held", int'(host.rx_data), 8'hA5);

        // two-byte read, ACK then NACK
        exp_ack.push_back(0);
        tx_supply.push_back(8'h3C); tx_supply.push_back(8'hC3);
        exp_byte.push_back(8'h3C); exp_byte.push_back(8'hC3);
        bus_start();
        wr_byte(8'h85);
        check("rd_rd_mode", int'(host.rd_mode), 1);
        check("rd_busy", int'(host.busy), 1);
        rd_byte(1'b0);
        rd_byte(1'b1);
        check("rd_busy_after_nack", int'(host.busy), 0);
        bus_stop(1'b0);
        check("rd_tx_supply_used", tx_supply.size(), 0);

        // write then repeated START into a read
        exp_ack.push_back(0); exp_ack.push_back(0); exp_ack.push_back(0);
        exp_rx.push_back(8'h01);
        tx_supply.push_back(8'h5A);
        exp_byte.push_back(8'h5A);
        bus_start();
        wr_byte(8'h84);
        check("rs_rd_mode_w", int'(host.rd_mode), 0);
        wr_byte(8'h01);
        bus_start();
        wr_byte(8'h85);
        check("rs_rd_mode_r", int'(host.rd_mode), 1);
        rd_byte(1'b1);
        bus_stop(1'b0);
        check("rs_rx_data", int'(host.rx_data), 8'h01);

        // reset in the middle of a read while bit 4 (a 0) is on the bus
        exp_ack.push_back(0);
        tx_supply.push_back(8'hA5);
        bus_start();
        wr_byte(8'h85);
        read_bit(b); check("mid_b7", b, 1);
        read_bit(b); check("mid_b6", b, 0);
        read_bit(b); check("mid_b5", b, 1);
        sda_drv_low = 1'b0;
        clk(T);
        check("mid_b4_driven_low", int'(sda === 1'b0), 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mid_rst_sda_released", int'(sda === 1'b1), 1);
        check("mid_rst_busy", int'(host.busy), 0);
        check("mid_rst_rd_mode", int'(host.rd_mode), 0);
        check("mid_rst_rx_data", int'(host.rx_data), 0);
        check("mid_rst_tx_req", int'(host.tx_req), 0);
        check("mid_rst_rx_valid", int'(host.rx_valid), 0);
        @(negedge clock);
        reset = 1'b0;
        clk(T);
        bus_stop(1'b0);
        exp_ack.push_back(0); exp_ack.push_back(0);
        exp_rx.push_back(8'h77);
        bus_start();
        wr_byte(8'h84);
        wr_byte(8'h77);
        bus_stop(1'b1);

`ifdef I2C_TARGET_STRETCH_EN
        // read with tx_valid held low for 50 clocks
        exp_ack.push_back(0);
        tx_supply.push_back(32'h100 | 8'h96);
        exp_byte.push_back(8'h96);
        bus_start();
        wr_byte(8'h85);
        rd_byte(1'b1);
        bus_stop(1'b0);
`else
        check("scl_never_driven", dut_scl_low_clks, 0);
`endif

        clk(20);
        check("left_exp_rx", exp_rx.size(), 0);
        check("left_exp_ack", exp_ack.size(), 0);
        check("left_exp_byte", exp_byte.size(), 0);
        check("left_tx_supply", tx_supply.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
